// File: rtl/hf_spi_readback_pkg.sv
// Shared constants and types for the ARM<->FPGA SPI readback path.
package hf_spi_readback_pkg;

    localparam int unsigned WORD_W_DEF = 16;
    localparam int unsigned CMD_W      = 4;

    localparam logic [CMD_W-1:0] FPGA_CMD_SET_CONFREG = 4'b0001;
    localparam logic [CMD_W-1:0] FPGA_CMD_READ_SEL    = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OVER  = 2'd2
    } state_e;

endpackage

// File: rtl/hf_spi_readback_sync_edge.sv
// Multi-flop synchronizer for one async input, with 1-cycle rise/fall pulses
// taken from the synchronized value.
module hf_spi_readback_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Shift the raw input into the chain; remember last synchronized value
    always_comb begin
        sync_d = STAGES'({sync_q, d});
        prev_d = sync_q[STAGES-1];
    end

    // Synchronizer and edge-history flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q      = sync_q[STAGES-1];
    assign rise_c = q & ~prev_q;
    assign fall_c = ~q & prev_q;

endmodule

// File: rtl/hf_spi_readback.sv
// SPI slave transmit path: snapshots one of NSRC status words at ncs fall and
// shifts it out MSB first on miso, while capturing a command word on mosi.
module hf_spi_readback
    import hf_spi_readback_pkg::*;
#(
    parameter int unsigned      WORD_W       = WORD_W_DEF,
    parameter int unsigned      NSRC         = 4,
    parameter int unsigned      SYNC_STAGES  = 2,
    parameter logic [CMD_W-1:0] CMD_READ_SEL = FPGA_CMD_READ_SEL
) (
    input  logic                       pck0,
    input  logic                       nreset,
    input  logic                       spck,
    input  logic                       ncs,
    input  logic                       mosi,
    input  logic [NSRC*WORD_W-1:0]     stat,
    output logic                       miso,
    output logic [$clog2(NSRC)-1:0]    sel,
    output logic                       rd_done,
    output logic                       frame_err
);

    localparam int unsigned SEL_W = $clog2(NSRC);
    localparam int unsigned CNT_W = $clog2(WORD_W) + 1;

    logic spck_s_unused;
    logic spck_rise_c;
    logic spck_fall_c;
    logic ncs_s;
    logic ncs_rise_c;
    logic ncs_fall_c;
    logic mosi_s;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    hf_spi_readback_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_spck (
        .clk    (pck0),
        .rst_n  (nreset),
        .d      (spck),
        .q      (spck_s_unused),
        .rise_c (spck_rise_c),
        .fall_c (spck_fall_c)
    );

    hf_spi_readback_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk    (pck0),
        .rst_n  (nreset),
        .d      (ncs),
        .q      (ncs_s),
        .rise_c (ncs_rise_c),
        .fall_c (ncs_fall_c)
    );

    hf_spi_readback_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk    (pck0),
        .rst_n  (nreset),
        .d      (mosi),
        .q      (mosi_s),
        .rise_c (mosi_rise_unused),
        .fall_c (mosi_fall_unused)
    );

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shadow_q, shadow_d;
    logic [WORD_W-1:0]   rx_q, rx_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                ovr_q, ovr_d;
    logic                glitch_q, glitch_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                miso_q, miso_d;
    logic                rd_done_q, rd_done_d;
    logic                frame_err_q, frame_err_d;

    logic                start_c;
    logic                end_c;
    logic                full_c;
    logic [WORD_W-1:0]   stat_sel_c;

    // Frame start/end qualifiers; an ncs fall outside IDLE ends the frame and restarts it next cycle
    always_comb begin
        start_c    = (state_q == ST_IDLE) && (ncs_fall_c || (glitch_q && !ncs_s));
        end_c      = (state_q != ST_IDLE) && (ncs_rise_c || ncs_fall_c);
        full_c     = (bit_cnt_q == CNT_W'(WORD_W));
        stat_sel_c = stat[sel_q*WORD_W +: WORD_W];
    end

    // FSM state register
    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; ncs events take priority over spck edges
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_c) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (end_c)                     state_d = ST_IDLE;
                else if (spck_fall_c && full_c) state_d = ST_OVER;
            end
            ST_OVER: begin
                if (end_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        shadow_d    = shadow_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        ovr_d       = ovr_q;
        glitch_d    = 1'b0;
        sel_d       = sel_q;
        miso_d      = 1'b0;
        rd_done_d   = 1'b0;
        frame_err_d = 1'b0;

        if (start_c) begin
            shadow_d  = stat_sel_c;
            rx_d      = '0;
            bit_cnt_d = '0;
            ovr_d     = 1'b0;
        end else if (end_c) begin
            if (full_c && !ovr_q) begin
                rd_done_d = 1'b1;
                if (rx_q[WORD_W-1 -: CMD_W] == CMD_READ_SEL) begin
                    sel_d = rx_q[SEL_W-1:0];
                end
            end else begin
                frame_err_d = 1'b1;
            end
            ovr_d    = 1'b0;
            glitch_d = ncs_fall_c;
        end else if (state_q == ST_SHIFT) begin
            miso_d = shadow_q[WORD_W-1];
            if (spck_rise_c) begin
                if (!full_c) begin
                    rx_d      = {rx_q[WORD_W-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end else begin
                    ovr_d = 1'b1;
                end
            end else if (spck_fall_c) begin
                if (!full_c) begin
                    shadow_d = shadow_q << 1;
                    miso_d   = shadow_q[WORD_W-2];
                end else begin
                    miso_d = 1'b0;
                end
            end
        end else if (state_q == ST_OVER) begin
            if (spck_rise_c) ovr_d = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            shadow_q    <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            ovr_q       <= 1'b0;
            glitch_q    <= 1'b0;
            sel_q       <= '0;
            miso_q      <= 1'b0;
            rd_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            ovr_q       <= ovr_d;
            glitch_q    <= glitch_d;
            sel_q       <= sel_d;
            miso_q      <= miso_d;
            rd_done_q   <= rd_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = miso_q;
    assign sel       = sel_q;
    assign rd_done   = rd_done_q;
    assign frame_err = frame_err_q;

endmodule
